// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD/LCM datapath.
//   GCD_W   : default operand / GCD width (the LCM result is twice this)
//   CNT_W   : width of an iteration counter able to hold GCD_W
//   cnt_w() : counter width for an arbitrary operand width
//   lcm_state_t : control states of the LCM sequencer
package gcd_pkg;

    localparam int GCD_W = 16;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_w(GCD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } lcm_state_t;

endpackage

// File: rtl/lcm_from_gcd_seq_divider.sv
// seq_divider: W-bit sequential restoring divider, one quotient bit per
// cycle, MSB first, W cycles per division.
//   clk, rst  : clock, synchronous active-high reset (control only)
//   start     : load dividend/divisor and perform the first iteration
//   dividend  : numerator, sampled on start
//   divisor   : denominator, sampled on start
//   done      : one-cycle pulse, quotient/remainder valid from this cycle on
//   quotient  : result, held until the next start
//   remainder : result, held until the next start
// The first iteration is performed in the start cycle itself, working
// straight from the input operands, so the last quotient bit lands W-1
// cycles after start and done is seen W cycles after the start edge.
module seq_divider
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = cnt_w(W);

    logic [W-1:0]  rem_r;
    logic [W-1:0]  quo_r;
    logic [W-1:0]  dvsr_r;
    logic [CW-1:0] cnt;
    logic          running;
    logic          load;

    logic [W-1:0]  rem_src;
    logic [W-1:0]  quo_src;
    logic [W-1:0]  dvsr_src;
    logic [W:0]    trial;
    logic          q_bit;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  quo_nxt;

    assign load = start && !running;

    // quo_r doubles as the dividend shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    always_comb begin
        rem_src  = rem_r;
        quo_src  = quo_r;
        dvsr_src = dvsr_r;
        if (load) begin
            rem_src  = '0;
            quo_src  = dividend;
            dvsr_src = divisor;
        end
        trial = {rem_src, quo_src[W-1]};
        if (trial >= {1'b0, dvsr_src}) begin
            q_bit   = 1'b1;
            // The difference is below the divisor, so W bits are enough.
            rem_nxt = trial[W-1:0] - dvsr_src;
        end else begin
            q_bit   = 1'b0;
            rem_nxt = trial[W-1:0];
        end
        quo_nxt = {quo_src[W-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                rem_r   <= rem_nxt;
                quo_r   <= quo_nxt;
                dvsr_r  <= divisor;
                cnt     <= CW'(1);
                running <= 1'b1;
            end else if (running) begin
                rem_r <= rem_nxt;
                quo_r <= quo_nxt;
                cnt   <= cnt + CW'(1);
                if (cnt == CW'(W-1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/lcm_from_gcd.sv
// lcm_from_gcd: computes LCM(a, b) = (a / g) * b from the GCD unit's result.
//   clk, rst   : clock, synchronous active-high reset
//   a_in, b_in : operand pair that fed the GCD unit (stable while gcd_rdy)
//   gcd_in     : GCD result
//   gcd_rdy    : GCD done level; a job starts on its rising transition
//   lcm_out    : 2W-bit LCM, valid while lcm_valid is high
//   lcm_valid  : result valid, held until lcm_ack
//   lcm_ack    : sink acknowledge, only looked at while lcm_valid is high
//   div_err    : gcd_in did not divide a_in exactly (qualified by lcm_valid)
//   busy       : high while dividing or multiplying
// Sequence: IDLE -> DIV (W cycles, seq_divider) -> MUL (W cycles shift-add)
// -> DONE. lcm_valid is registered one cycle behind entry into DONE.
module lcm_from_gcd
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    input  logic [W-1:0]   gcd_in,
    input  logic           gcd_rdy,
    output logic [2*W-1:0] lcm_out,
    output logic           lcm_valid,
    input  logic           lcm_ack,
    output logic           div_err,
    output logic           busy
);

    localparam int CW = cnt_w(W);

    lcm_state_t     state;
    logic           rdy_q;
    logic           start;
    logic           div_start;
    logic           div_done;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;

    logic [W-1:0]   b_reg;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nxt;
    logic [CW-1:0]  cnt;

    // rdy_q resets high so a gcd_rdy still high after reset is not an edge.
    assign start     = gcd_rdy && !rdy_q;
    assign div_start = start && (state == IDLE) && (gcd_in != '0);

    seq_divider #(
        .W(W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a_in),
        .divisor  (gcd_in),
        .done     (div_done),
        .quotient (quo),
        .remainder(rem)
    );

    // q * b <= (2^W-1)^2 always fits in 2W bits, so no carry out is lost.
    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) begin
            acc_nxt = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdy_q     <= 1'b1;
            lcm_out   <= '0;
            lcm_valid <= 1'b0;
            div_err   <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            rdy_q <= gcd_rdy;
            case (state)
                IDLE: begin
                    lcm_valid <= 1'b0;
                    if (start) begin
                        b_reg   <= b_in;
                        div_err <= 1'b0;
                        if (gcd_in == '0) begin
                            lcm_out <= '0;
                            state   <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (div_done) begin
                        if (rem != '0) begin
                            div_err <= 1'b1;
                            lcm_out <= '0;
                            busy    <= 1'b0;
                            state   <= DONE;
                        end else begin
                            mcand  <= {{W{1'b0}}, b_reg};
                            mplier <= quo;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(W-1)) begin
                        lcm_out <= acc_nxt;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // Any start edge seen here, including one coincident
                    // with the exiting ack, is intentionally discarded.
                    if (lcm_valid && lcm_ack) begin
                        lcm_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        lcm_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_from_gcd.sv
module tb_lcm_from_gcd;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_in, b_in, gcd_in;
    logic        gcd_rdy;
    logic [31:0] lcm_out;
    logic        lcm_valid;
    logic        lcm_ack;
    logic        div_err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    lcm_from_gcd dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .b_in     (b_in),
        .gcd_in   (gcd_in),
        .gcd_rdy  (gcd_rdy),
        .lcm_out  (lcm_out),
        .lcm_valid(lcm_valid),
        .lcm_ack  (lcm_ack),
        .div_err  (div_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a, b, g;
        logic [31:0] exp_out;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: LCM via plain arithmetic; latency counted in edges after the
    // start-sampling edge until lcm_valid is seen.
    task automatic ref_model(input logic [15:0] a, b, g,
                             output logic [31:0] out, output logic err, output int lat);
        longint unsigned q, r;
        if (g == 0) begin
            out = 0; err = 0; lat = 1;
        end else begin
            q = a / g;
            r = a % g;
            if (r != 0) begin
                out = 0; err = 1; lat = 17;
            end else begin
                out = 32'(q * b); err = 0; lat = 33;
            end
        end
    endtask

    // Issue a fresh rising edge and wait (bounded) for lcm_valid.
    task automatic start_and_wait(input logic [15:0] a, b, g,
                                  output int n, output logic busy_seen);
        gcd_rdy = 1'b0;
        tick();
        a_in = a; b_in = b; gcd_in = g;
        gcd_rdy = 1'b1;
        tick();
        n = 0;
        busy_seen = busy;
        while (!lcm_valid && n < 100) begin
            tick();
            n++;
            if (busy) busy_seen = 1'b1;
        end
    endtask

    task automatic do_ack();
        lcm_ack = 1'b1;
        tick();
        lcm_ack = 1'b0;
    endtask

    task automatic run_checked(input string tag, input logic [15:0] a, b, g,
                               input logic [31:0] eo, input logic ee, input int el);
        int   n;
        logic bs;
        start_and_wait(a, b, g, n, bs);
        check({tag, " latency"}, 64'(n), 64'(el));
        check({tag, " lcm_out"}, 64'(lcm_out), 64'(eo));
        check({tag, " div_err"}, 64'(div_err), 64'(ee));
        check({tag, " busy_seen"}, 64'(bs), 64'(g != 0));
        do_ack();
        check({tag, " valid_after_ack"}, 64'(lcm_valid), 64'(0));
    endtask

    vec_t vecs[10];

    initial begin
        int   n;
        logic bs;
        logic [31:0] eo;
        logic        ee;
        int          el;

        vecs[0] = '{16'd48,    16'd18,    16'd6,  32'd144,        1'b0, 33};
        vecs[1] = '{16'd65535, 16'd65534, 16'd1,  32'hFFFD0002,   1'b0, 33};
        vecs[2] = '{16'd0,     16'd7,     16'd0,  32'd0,          1'b0, 1};
        vecs[3] = '{16'd10,    16'd4,     16'd3,  32'd0,          1'b1, 17};
        vecs[4] = '{16'd0,     16'd9,     16'd5,  32'd0,          1'b0, 33};
        vecs[5] = '{16'd21,    16'd6,     16'd3,  32'd42,         1'b0, 33};
        vecs[6] = '{16'd65535, 16'd65535, 16'd1,  32'hFFFE0001,   1'b0, 33};
        vecs[7] = '{16'd7,     16'd5,     16'd7,  32'd5,          1'b0, 33};
        vecs[8] = '{16'd65535, 16'd1,     16'd3,  32'd21845,      1'b0, 33};
        vecs[9] = '{16'd100,   16'd7,     16'd0,  32'd0,          1'b0, 1};

        rst = 1'b1; gcd_rdy = 1'b1; lcm_ack = 1'b0;
        a_in = 16'd48; b_in = 16'd18; gcd_in = 16'd6;
        tick(); tick();
        check("reset lcm_out", 64'(lcm_out), 0);
        check("reset lcm_valid", 64'(lcm_valid), 0);
        check("reset div_err", 64'(div_err), 0);
        check("reset busy", 64'(busy), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("stale rdy busy", 64'(busy), 0);
        check("stale rdy valid", 64'(lcm_valid), 0);

        for (int i = 0; i < 10; i++)
            run_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].g,
                        vecs[i].exp_out, vecs[i].exp_err, vecs[i].exp_lat);

        // Result held stable without ack.
        start_and_wait(16'd48, 16'd18, 16'd6, n, bs);
        check("hold latency", 64'(n), 33);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold valid %0d", i), 64'(lcm_valid), 1);
            check($sformatf("hold out %0d", i), 64'(lcm_out), 144);
        end
        do_ack();
        check("hold valid_after_ack", 64'(lcm_valid), 0);
        tick();
        check("hold out kept", 64'(lcm_out), 144);

        // Reset during MUL, stale gcd_rdy, then a fresh job.
        gcd_rdy = 1'b0; tick();
        a_in = 16'd48; b_in = 16'd18; gcd_in = 16'd6; gcd_rdy = 1'b1;
        tick();
        for (int i = 0; i < 22; i++) tick();
        check("mid-mul busy", 64'(busy), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort lcm_out", 64'(lcm_out), 0);
        check("abort valid", 64'(lcm_valid), 0);
        check("abort busy", 64'(busy), 0);
        check("abort div_err", 64'(div_err), 0);
        bs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy || lcm_valid) bs = 1'b1;
        end
        check("abort no restart", 64'(bs), 0);
        run_checked("after_abort", 16'd48, 16'd18, 16'd6, 32'd144, 1'b0, 33);

        // Second rising edge during DIV is dropped.
        gcd_rdy = 1'b0; tick();
        a_in = 16'd48; b_in = 16'd18; gcd_in = 16'd6; gcd_rdy = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 3; i++) begin tick(); n++; end
        gcd_rdy = 1'b0; tick(); n++;
        a_in = 16'd21; b_in = 16'd6; gcd_in = 16'd3; gcd_rdy = 1'b1;
        tick(); n++;
        while (!lcm_valid && n < 100) begin tick(); n++; end
        check("drop latency", 64'(n), 33);
        check("drop lcm_out", 64'(lcm_out), 144);
        do_ack();
        bs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy || lcm_valid) bs = 1'b1;
        end
        check("drop no restart", 64'(bs), 0);
        run_checked("after_drop", 16'd21, 16'd6, 16'd3, 32'd42, 1'b0, 33);

        // Start edge coincident with the exiting ack is dropped.
        start_and_wait(16'd12, 16'd12, 16'd12, n, bs);
        check("ackedge out", 64'(lcm_out), 12);
        gcd_rdy = 1'b0; tick();
        a_in = 16'd48; b_in = 16'd18; gcd_in = 16'd6;
        gcd_rdy = 1'b1; lcm_ack = 1'b1;
        tick();
        lcm_ack = 1'b0;
        bs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy || lcm_valid) bs = 1'b1;
        end
        check("ackedge no start", 64'(bs), 0);

        // Randomised jobs against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb, rg;
            int unsigned q;
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: begin ra = 16'($urandom); rg = 16'($urandom_range(0, 40)); end
                1: begin
                    rg = 16'($urandom_range(1, 300));
                    q  = $urandom_range(0, 65535 / int'(rg));
                    ra = 16'(q * rg);
                end
                2: begin ra = 16'($urandom); rg = 16'd0; end
                default: begin ra = 16'($urandom); rg = 16'd1; end
            endcase
            ref_model(ra, rb, rg, eo, ee, el);
            run_checked($sformatf("rnd%0d", i), ra, rb, rg, eo, ee, el);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcm_from_gcd.md
Name: lcm_from_gcd

Overview:
- Downstream consumer of the GCD datapath. It takes the GCD result (`g`) together with the same operand pair (`a`, `b`) that fed the GCD unit.
- Computes LCM = (a / g) * b in sequence: a 16-iteration restoring divider, then a 16-iteration shift-add multiplier.
- Presents the 2W-bit result on a valid/ack output handshake.
- Sits between the GCD unit's `xo`/`rdy` outputs and the result sink.

Parameters:
- W, 16, operand and GCD width. The LCM result is 2*W bits.

Ports:
- clk  input  1  single clock, all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- a_in  input  W  operand x; held stable by upstream while gcd_rdy is high
- b_in  input  W  operand y; held stable by upstream while gcd_rdy is high
- gcd_in  input  W  GCD result (GCD unit `xo`)
- gcd_rdy  input  1  GCD done level (GCD unit `rdy`); a new job starts on its 0->1 transition
- lcm_out  output  2*W  LCM result; valid while lcm_valid is high
- lcm_valid  output  1  result valid; held until acknowledged
- lcm_ack  input  1  sink acknowledge; sampled only while lcm_valid is high
- div_err  output  1  gcd_in did not divide a_in exactly; qualified by lcm_valid
- busy  output  1  high in DIV and MUL states

Behaviour:
- Reset state and outputs:
  - rst=1 at a clock edge forces state IDLE.
  - Forces lcm_out=0, lcm_valid=0, div_err=0, busy=0.
  - Forces rdy_q (registered gcd_rdy) = 1, so a stale, still-high gcd_rdy after reset does not start a job.
- Start condition: start = gcd_rdy & ~rdy_q. rdy_q updates every non-reset cycle, in every state.
- IDLE:
  - On start, capture a_in, b_in and gcd_in into internal registers.
  - If gcd_in==0: go to DONE with lcm_out=0, div_err=0, so lcm_valid is high one cycle after the start edge.
  - Otherwise: go to DIV with iteration counter=0; busy=1.
- DIV (restoring division of a by g):
  - One quotient bit per cycle, MSB first; exactly W cycles.
  - After the last iteration:
    - remainder!=0: go to DONE with div_err=1, lcm_out=0.
    - remainder==0: go to MUL.
- MUL (shift-add of quotient q by b):
  - One multiplier bit per cycle; exactly W cycles.
  - The product accumulates in a 2W-bit register; no overflow is possible, since q*b <= (2^W-1)^2.
  - After the last iteration go to DONE.
- DONE:
  - lcm_valid=1; lcm_out and div_err stay stable.
  - On lcm_ack=1, clear lcm_valid next cycle and return to IDLE.
  - lcm_out keeps its last value until the next job overwrites it.
- Latency (normal path): start sampled at edge E0 -> lcm_valid high after edge E0+1+2W (E33 for W=16).
- Boundary conditions:
  - A start edge in DIV/MUL/DONE is dropped, not queued. Upstream must drop gcd_rdy and raise it again to issue a new job.
  - A start edge in the same cycle as the lcm_ack that exits DONE is dropped.
  - rst during DIV/MUL/DONE aborts the job immediately with no result.
  - a_in=0 with gcd_in!=0 gives q=0 and lcm_out=0 via the full path, div_err=0.
  - gcd_in=1 gives lcm_out = a*b.

Decomposition:
- Shared package gcd_pkg holds:
  - `W` default
  - state typedef `lcm_state_t` {IDLE, DIV, MUL, DONE}
  - `CNT_W` = $clog2(W)+1 for the iteration counter
- One natural sub-module: `seq_divider`, a W-bit restoring divider with start/done, quotient and remainder. It is reusable elsewhere in the datapath.
- The multiplier stays inline.

Test Plan:
- a=48, b=18, g=6, gcd_rdy 0->1 -> lcm_valid high 33 cycles after the edge, lcm_out=144, div_err=0; hold lcm_ack=0 for 5 cycles -> lcm_out/lcm_valid stable; ack -> IDLE.
- a=65535, b=65534, g=1 -> lcm_out=0xFFFD0002 (4294770690) at E+33, div_err=0.
- a=0, b=7, g=0 -> lcm_valid at E+1, lcm_out=0, busy never asserted.
- a=10, b=4, g=3 (inconsistent) -> lcm_valid at E+17, div_err=1, lcm_out=0.
- Start a=48, b=18, g=6; assert rst for 1 cycle during MUL -> next cycle IDLE with all outputs 0. gcd_rdy held high -> no restart. Toggle gcd_rdy 0->1 -> job completes with lcm_out=144.
- Second gcd_rdy edge (a=21, b=6, g=3) during DIV of a first job -> ignored, first result delivered. After ack, a fresh edge -> lcm_out=42.
